// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO.
// Shift-add multiply, restoring divide, sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             hilo_rd_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIXUP
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_mul;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_m1;
  logic [WIDTH-1:0]   r_m2;
  logic [WIDTH-1:0]   r_d1;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_s1;
  logic               w_s2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  assign busy_o  = (r_state != S_IDLE);
  assign stall_o = busy_o & (start_i | hilo_rd_i);

  // operand magnitudes for signed ops (op_i[0] = signed)
  assign w_s1   = op_i[0] & data1_i[WIDTH-1];
  assign w_s2   = op_i[0] & data2_i[WIDTH-1];
  assign w_mag1 = w_s1 ? -data1_i : data1_i;
  assign w_mag2 = w_s2 ? -data2_i : data2_i;

  // multiply step: conditional add into upper half, then shift right
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + (r_acc[0] ? {1'b0, r_m1} : '0);

  // divide step: shift in next dividend bit, trial subtract
  assign w_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m2});
  assign w_sub   = WIDTH'(w_shift - {1'b0, r_m2});

  // sign fix-up of the magnitude results
  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rmd  = r_neg_r ? -r_rem : r_rem;

  // sequencer FSM with datapath and HI/LO commit
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_m1    <= '0;
      r_m2    <= '0;
      r_d1    <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      done_o  <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_state <= S_CALC;
              r_cnt   <= '0;
              r_mul   <= ~op_i[1];
              r_neg_q <= w_s1 ^ w_s2;
              r_neg_r <= w_s1;
              r_dz    <= (data2_i == '0);
              r_m1    <= w_mag1;
              r_m2    <= w_mag2;
              r_d1    <= data1_i;
              r_rem   <= '0;
              r_acc   <= {{WIDTH{1'b0}},
                          op_i[1] ? w_mag1 : w_mag2};
            end
          end
          S_CALC: begin
            if (r_mul) begin
              r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            end else begin
              r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
              r_acc <= {r_acc[2*WIDTH-1:WIDTH],
                        r_acc[WIDTH-2:0], w_ge};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIXUP;
          end
          S_FIXUP: begin
            r_state <= S_IDLE;
            done_o  <= 1'b1;
            if (r_mul) begin
              hi_o <= w_prod[2*WIDTH-1:WIDTH];
              lo_o <= w_prod[WIDTH-1:0];
            end else if (r_dz) begin
              hi_o <= r_d1;
              lo_o <= '1;
            end else begin
              hi_o <= w_rmd;
              lo_o <= w_quo;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Directed cases, stall/abort/reset, random ops vs model.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] d1 = '0;
  logic [W-1:0] d2 = '0;
  logic         hrd = 1'b0;
  logic         abrt = 1'b0;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .op_i(op),
    .data1_i(d1),
    .data2_i(d2),
    .hilo_rd_i(hrd),
    .abort_i(abrt),
    .busy_o(busy),
    .stall_o(stall),
    .done_o(done),
    .hi_o(hi),
    .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference result {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    u = '0;
    case (o)
      2'd0: u = {32'b0, a} * {32'b0, b};
      2'd1: begin p = sa * sb; u = p; end
      default: begin
        if (b == 0) u = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) u = {a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          u = {r[31:0], q[31:0]};
        end
      end
    endcase
    return u;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // issue one op, check latency, busy length, result, pulse width
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int lat, bc;
    e = ref_op(o, a, b);
    op = o; d1 = a; d2 = b; start = 1'b1;
    step();
    start = 1'b0;
    d1 = $urandom; d2 = $urandom; op = 2'($urandom);
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy"}, 64'(bc), 64'(LAT));
    chk({tag, "_hilo"}, {hi, lo}, e);
    step();
    chk({tag, "_pulse"}, {63'b0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] prev, ea, eb;
    int lat, sc, dc;

    #2;
    chk("rst_state", {busy, stall, done, hi, lo}, '0);
    step();
    rst = 1'b1;
    step();

    do_op("multu_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_ff_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_m3x7", 2'd1, -32'sd3, 32'd7);
    chk("mult_m3x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("mult_m2xm2", 2'd1, -32'sd2, -32'sd2);
    chk("mult_m2xm2_const", {hi, lo}, 64'd4);
    do_op("div_m7d2", 2'd3, -32'sd7, 32'd2);
    chk("div_m7d2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_100d7", 2'd2, 32'd100, 32'd7);
    chk("divu_100d7_const", {hi, lo}, {32'd2, 32'd14});
    do_op("div_ovf", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("divu_by0", 2'd2, 32'd5, 32'd0);
    chk("divu_by0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op("div_by0", 2'd3, -32'sd5, 32'd0);
    chk("div_by0_const", {hi, lo}, 64'hFFFF_FFFB_FFFF_FFFF);

    // HI/LO read held from CALC cycle 3
    ea = ref_op(2'd1, 32'd12345, -32'sd678);
    op = 2'd1; d1 = 32'd12345; d2 = -32'sd678; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0; sc = 0;
    while (!done && lat < 40) begin
      if (lat == 3) hrd = 1'b1;
      if (stall) sc++;
      step();
      lat++;
    end
    chk("hrd_stall_cycles", 64'(sc), 64'(LAT - 3));
    chk("hrd_lat", 64'(lat), 64'(LAT));
    chk("hrd_unstall", {63'b0, stall}, 64'd0);
    chk("hrd_newval", {hi, lo}, ea);
    hrd = 1'b0;
    step();

    // second start held through busy, accepted in done cycle
    ea = ref_op(2'd2, 32'd1000, 32'd33);
    eb = ref_op(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
    op = 2'd2; d1 = 32'd1000; d2 = 32'd33; start = 1'b1;
    step();
    op = 2'd0; d1 = 32'hDEAD_BEEF; d2 = 32'h1234_5678;
    lat = 0; sc = 0;
    while (!done && lat < 40) begin
      if (stall) sc++;
      step();
      lat++;
    end
    chk("held_stall_cycles", 64'(sc), 64'(LAT));
    chk("held_first_lat", 64'(lat), 64'(LAT));
    chk("held_done_nostall", {63'b0, stall}, 64'd0);
    chk("held_first_res", {hi, lo}, ea);
    step();
    start = 1'b0;
    chk("held_accepted", {63'b0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    chk("held_second_lat", 64'(lat), 64'(LAT));
    chk("held_second_res", {hi, lo}, eb);
    step();

    // abort at CALC cycle 10
    prev = {hi, lo};
    op = 2'd3; d1 = 32'd999; d2 = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    abrt = 1'b1;
    step();
    abrt = 1'b0;
    chk("abort_idle", {63'b0, busy}, 64'd0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      step();
    end
    chk("abort_nodone", 64'(dc), 64'd0);
    chk("abort_hilo", {hi, lo}, prev);

    // abort and start together in IDLE
    op = 2'd0; d1 = 32'd3; d2 = 32'd3; start = 1'b1; abrt = 1'b1;
    step();
    start = 1'b0; abrt = 1'b0;
    chk("abort_wins", {63'b0, busy}, 64'd0);

    // random ops against the model
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      logic [1:0] o;
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 300);
        2: b = -32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 5000);
      do_op($sformatf("rnd%0d", i), o, a, b);
    end

    // asynchronous reset mid-CALC
    op = 2'd1; d1 = 32'd77; d2 = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_done", {63'b0, done}, 64'd0);
    step();
    rst = 1'b1;
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dc++;
      step();
    end
    chk("rst_nodone", 64'(dc), 64'd0);
    do_op("post_rst", 2'd1, -32'sd9, 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit and sequencer for the CPU datapath, serving MULT/MULTU/DIV/DIVU and owning the HI/LO registers. It accepts an operation from the execute stage, runs a WIDTH-cycle shift-add or restoring-divide loop, applies sign fix-up, and then writes HI/LO. It generates the stall request that freezes the pipeline when a new mul/div or a HI/LO read (MFHI/MFLO) arrives while it is busy.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; the loop iterates WIDTH times.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  issue request for a mul/div op (level, held by stalled pipeline)
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
data1_i  input  WIDTH  rs operand (multiplicand / dividend)
data2_i  input  WIDTH  rt operand (multiplier / divisor)
hilo_rd_i  input  1  MFHI/MFLO in execute stage this cycle
abort_i  input  1  flush: cancel the in-flight op
busy_o  output  1  state != IDLE (combinational from state)
stall_o  output  1  busy_o & (start_i | hilo_rd_i)
done_o  output  1  one-cycle pulse: HI/LO were just updated
hi_o  output  WIDTH  HI register (high product / remainder)
lo_o  output  WIDTH  LO register (low product / quotient)

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; hi_o, lo_o, done_o and all internal registers are 0. A reset mid-operation discards the op with no done_o.
- States: IDLE, CALC, FIXUP.
- IDLE: if start_i is high at the edge, capture op_i, data1_i, data2_i and go to CALC. From then on, input changes have no effect.
- Signed ops: convert operands to magnitudes and record sign bits first. For MULT the result sign is s1^s2. For DIV the quotient sign is s1^s2 and the remainder sign is s1.
- CALC: a counter runs 0..WIDTH-1, one iteration per cycle, then goes to FIXUP.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
- FIXUP (one cycle): negate results per the sign rules, then write the registers.
  - Multiply: hi_o = product[2W-1:W], lo_o = product[W-1:0].
  - Divide: lo_o = quotient, hi_o = remainder.
  - At the same edge, done_o becomes 1 for exactly one cycle and the state returns to IDLE.
- Latency: start sampled at edge k. HI/LO are valid and done_o is high after edge k+WIDTH+1. busy_o is high for WIDTH+1 cycles.
- Divide by zero (divisor == 0, signed or unsigned): lo_o = all ones and hi_o = captured data1, with no sign fix-up.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo_o = 0x80000000 and hi_o = 0. This falls out of magnitude arithmetic truncated to WIDTH bits.
- start_i while busy is not accepted. stall_o holds the pipeline, and the held request is accepted at the first edge in IDLE. In the done_o cycle the state is already IDLE, so it is accepted then.
- hilo_rd_i while busy asserts stall_o. hi_o/lo_o always show the last committed result, so the reader unstalls in the done_o cycle and sees new values.
- abort_i (any state other than IDLE): go to IDLE at the next edge. HI/LO are unchanged and done_o stays 0. abort_i and start_i in IDLE together: abort wins and start is ignored.
- No combinational path from data*_i to any output. stall_o depends only on state, start_i and hilo_rd_i.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. done_o high exactly 33 cycles after the start edge; busy_o high for 33 cycles.
2. MULT -3 * 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB. MULT -2 * -2 -> hi_o=0, lo_o=4.
3. DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100 / 7 -> lo_o=14, hi_o=2. DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
4. DIVU 5 / 0 -> lo_o=0xFFFFFFFF, hi_o=5. DIV -5 / 0 -> lo_o=0xFFFFFFFF, hi_o=0xFFFFFFFB.
5. Stall checks:
   - hilo_rd_i held from cycle 3 of CALC -> stall_o=1 until the done_o cycle, where it is 0 and hi_o/lo_o hold the new result.
   - Second start_i held during busy -> stall_o=1, accepted in the done_o cycle, second result follows 33 cycles later.
6. Abort and reset:
   - abort_i at CALC cycle 10 -> IDLE next cycle, no done_o, HI/LO keep the previous result.
   - rst_i low mid-CALC -> immediately IDLE with hi_o=lo_o=0 and done_o=0.
